// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM with parameterised memory wait states
// Optional illegal-instruction trap: define MC_CTRL_ILLEGAL_TRAP_EN to halt on unsupported encodings.
module mc_ctrl #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        mem_wr,
  output logic        ext_ori,
  output logic        ext_lui,
  output logic [2:0]  alu_op,
  output logic        b_sel,
  output logic [1:0]  a3_sel,
  output logic [1:0]  wd_sel,
  output logic [1:0]  npc_sel,
  output logic [3:0]  state,
  output logic        illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXE    = 4'd2;
  localparam logic [3:0] S_WB_ALU = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [2:0] WAIT_N = 3'(MEM_WAIT);

  if (MEM_WAIT < 0 || MEM_WAIT > 7) begin : g_bad_mem_wait
    $error("mc_ctrl: MEM_WAIT must be in 0..7");
  end

  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c;

  logic [5:0] op, funct;
  logic is_r, is_addu, is_subu, is_jr, is_nop, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_ill;

  always_comb begin
    op      = instr[31:26];
    funct   = instr[5:0];
    is_r    = (op == 6'b000000);
    is_addu = is_r && (funct == 6'b100001);
    is_subu = is_r && (funct == 6'b100011);
    is_jr   = is_r && (funct == 6'b001000);
    is_nop  = (instr == 32'd0);
    is_ori  = (op == 6'b001101);
    is_lui  = (op == 6'b001111);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_beq  = (op == 6'b000100);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
    is_ill  = !(is_addu || is_subu || is_jr || is_nop || is_ori || is_lui ||
                is_lw || is_sw || is_beq || is_j || is_jal);
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_wr_c  = 1'b0;
    ir_wr_c  = 1'b0;
    reg_wr_c = 1'b0;
    mem_wr_c = 1'b0;
    alu_op   = ALU_ADD;
    b_sel    = 1'b0;
    a3_sel   = 2'd0;
    wd_sel   = 2'd0;
    npc_sel  = 2'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        pc_wr_c = 1'b1;
        ir_wr_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXE;
        else if (is_lw || is_sw)                    state_d = S_ADDR;
        else if (is_beq)                            state_d = S_BRANCH;
        else if (is_j || is_jal || is_jr)           state_d = S_JUMP;
        else if (is_ill) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d = S_FETCH;
`endif
        end
        else state_d = S_FETCH;
      end
      S_EXE: begin
        alu_op  = is_subu ? ALU_SUB : (is_ori ? ALU_OR : ALU_ADD);
        b_sel   = is_ori || is_lui;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_wr_c = 1'b1;
        a3_sel   = is_r ? 2'd1 : 2'd0;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        b_sel   = 1'b1;
        cnt_d   = 3'd0;
        state_d = is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (cnt_q == WAIT_N) state_d = S_WB_MEM;
        else                 cnt_d   = cnt_q + 3'd1;
      end
      S_WB_MEM: begin
        reg_wr_c = 1'b1;
        wd_sel   = 2'd1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        // Strobe the write only once the memory has had its wait cycles.
        if (cnt_q == WAIT_N) begin
          mem_wr_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        pc_wr_c = zero;
        npc_sel = zero ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_wr_c = 1'b1;
        npc_sel = is_jr ? 2'd3 : 2'd2;
        if (is_jal) begin
          reg_wr_c = 1'b1;
          a3_sel   = 2'd2;
          wd_sel   = 2'd2;
        end
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Reset resolves to FETCH, whose enables must not leak while reset is held.
  assign pc_wr   = pc_wr_c  && !reset;
  assign ir_wr   = ir_wr_c  && !reset;
  assign reg_wr  = reg_wr_c && !reset;
  assign mem_wr  = mem_wr_c && !reset;
  assign ext_ori = (state_q != S_FETCH) && is_ori;
  assign ext_lui = (state_q != S_FETCH) && is_lui;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against an instruction-trace model
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-encoding expectations.
module tb_mc_ctrl;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        pc_wr, ir_wr, reg_wr, mem_wr, ext_ori, ext_lui, b_sel, illegal;
  logic [2:0]  alu_op;
  logic [1:0]  a3_sel, wd_sel, npc_sel;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mc_ctrl #(.MEM_WAIT(W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .ext_ori(ext_ori), .ext_lui(ext_lui), .alu_op(alu_op), .b_sel(b_sel),
    .a3_sel(a3_sel), .wd_sel(wd_sel), .npc_sel(npc_sel), .state(state),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs();
    return {11'd0, state, pc_wr, ir_wr, reg_wr, mem_wr, alu_op, b_sel,
            a3_sel, wd_sel, npc_sel, ext_ori, ext_lui, illegal};
  endfunction

  function automatic logic [31:0] pk(input int st, input int pc, input int ir, input int rw,
                                     input int mw, input int alu, input int bs, input int a3,
                                     input int wd, input int npc, input int eo, input int el,
                                     input int il);
    return {11'd0, 4'(st), 1'(pc), 1'(ir), 1'(rw), 1'(mw), 3'(alu), 1'(bs),
            2'(a3), 2'(wd), 2'(npc), 1'(eo), 1'(el), 1'(il)};
  endfunction

  // Expected per-cycle outputs for one instruction, from the instruction's class.
  task automatic build(input logic [31:0] ins, input logic z);
    logic [5:0] op;
    logic [5:0] fn;
    bit r, addu, subu, jr, nop, ori, lui, lw, sw, beq, j, jal, ill;
    int eo, el;
    op = ins[31:26]; fn = ins[5:0];
    r = (op == 6'h00);
    addu = r && fn == 6'h21; subu = r && fn == 6'h23; jr = r && fn == 6'h08;
    nop = (ins == 32'd0);
    ori = op == 6'h0D; lui = op == 6'h0F; lw = op == 6'h23; sw = op == 6'h2B;
    beq = op == 6'h04; j = op == 6'h02; jal = op == 6'h03;
    ill = !(addu || subu || jr || nop || ori || lui || lw || sw || beq || j || jal);
    eo = ori ? 1 : 0; el = lui ? 1 : 0;
    exp_q.delete();
    exp_q.push_back(pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, el, 0));
    if (addu || subu || ori || lui) begin
      exp_q.push_back(pk(2, 0, 0, 0, 0, subu ? 1 : (ori ? 2 : 0), (ori || lui) ? 1 : 0,
                         0, 0, 0, eo, el, 0));
      exp_q.push_back(pk(3, 0, 0, 1, 0, 0, 0, (addu || subu) ? 1 : 0, 0, 0, eo, el, 0));
    end else if (lw || sw) begin
      exp_q.push_back(pk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= W; i++)
        exp_q.push_back(pk(lw ? 5 : 7, 0, 0, 0, (sw && i == W) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (lw) exp_q.push_back(pk(6, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    end else if (beq) begin
      exp_q.push_back(pk(8, z ? 1 : 0, 0, 0, 0, 1, 0, 0, 0, z ? 1 : 0, 0, 0, 0));
    end else if (j || jal || jr) begin
      exp_q.push_back(pk(9, 1, 0, jal ? 1 : 0, 0, 0, 0, jal ? 2 : 0, jal ? 2 : 0,
                         jr ? 3 : 2, 0, 0, 0));
    end
  endtask

  // Entered just after the edge that starts FETCH; leaves just after the edge ending step n.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int n);
    build(ins, z);
    instr = ins;
    zero  = z;
    for (int i = 0; i < exp_q.size() && (n < 0 || i < n); i++) begin
      @(negedge clk);
      check($sformatf("i%08h_c%0d", ins, i), obs(), exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] gen(input int kind);
    logic [31:0] rnd;
    logic [5:0]  op;
    logic [5:0]  fn;
    rnd = $urandom;
    case (kind)
      0:  return {6'h00, rnd[25:6], 6'h21};
      1:  return {6'h00, rnd[25:6], 6'h23};
      2:  return {6'h00, rnd[25:6], 6'h08};
      3:  return 32'd0;
      4:  return {6'h0D, rnd[25:0]};
      5:  return {6'h0F, rnd[25:0]};
      6:  return {6'h23, rnd[25:0]};
      7:  return {6'h2B, rnd[25:0]};
      8:  return {6'h04, rnd[25:0]};
      9:  return {6'h02, rnd[25:0]};
      10: return {6'h03, rnd[25:0]};
      default: begin
        if (rnd[31]) begin
          fn = 6'($urandom);
          for (int k = 0; k < 50 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h08); k++)
            fn = 6'($urandom);
          if (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'h3F;
          return {6'h00, rnd[25:7], 1'b1, fn};
        end
        op = 6'($urandom);
        for (int k = 0; k < 50 && (op == 6'h00 || op == 6'h0D || op == 6'h0F || op == 6'h23 ||
             op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h03); k++)
          op = 6'($urandom);
        if (op == 6'h00 || op == 6'h0D || op == 6'h0F || op == 6'h23 ||
            op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h03) op = 6'h3F;
        return {op, rnd[25:0]};
      end
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs(), 32'd0);
    reset = 1'b0;

    run_instr(32'h00221821, 1'b0, -1);
    run_instr(32'h8C220004, 1'b0, -1);
    run_instr(32'h10220003, 1'b0, -1);
    run_instr(32'h10220003, 1'b1, -1);
    run_instr(32'h3422FFFF, 1'b0, -1);
    run_instr(32'h3C021234, 1'b0, -1);
    run_instr(32'h0C000010, 1'b0, -1);
    run_instr(32'h03E00008, 1'b1, -1);
    run_instr(32'h00000000, 1'b0, -1);

    // Reset pulsed while sw sits in its wait cycles.
    run_instr(32'hAC220008, 1'b0, 4);
    #2 reset = 1'b1;
    #1 check("rst_mid_wait", obs(), 32'd0);
    @(negedge clk);
    check("rst_hold", obs(), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(32'hAC220008, 1'b0, -1);

    for (int t = 0; t < 150; t++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      run_instr(gen($urandom_range(0, 10)), 1'($urandom), -1);
`else
      run_instr(gen($urandom_range(0, 11)), 1'($urandom), -1);
`endif
    end

    run_instr(32'hFC000000, 1'b0, -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("halt_%0d", i), obs(), pk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
      #1 zero = 1'($urandom);
    end
    reset = 1'b1;
    #1 check("halt_reset", obs(), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
`endif
    run_instr(32'h00221823, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
